// File: rtl/frogger_lane_hazard_pkg.sv
// -----------------------------------------------------------------------------
// frogger_lane_hazard_pkg
// Shared definitions for the Frogger lane/obstacle engine: tile codes, row map
// boundaries, lane count and the per-lane seed / period / direction tables.
// Lane index 0..4 covers water rows 1..5, lane index 5..10 covers road rows 7..12.
// -----------------------------------------------------------------------------
package frogger_lane_hazard_pkg;

    localparam int NUM_LANES = 11;
    localparam int LANE_W    = 20;

    typedef enum logic [3:0] {
        TILE_SAFE  = 4'd0,
        TILE_ROAD  = 4'd1,
        TILE_WATER = 4'd2,
        TILE_LOG   = 4'd3,
        TILE_PAD   = 4'd4,
        TILE_CAR   = 4'd5
    } tile_e;

    localparam logic [5:0] ROW_HOME        = 6'd0;
    localparam logic [5:0] ROW_WATER_FIRST = 6'd1;
    localparam logic [5:0] ROW_WATER_LAST  = 6'd5;
    localparam logic [5:0] ROW_ROAD_FIRST  = 6'd7;
    localparam logic [5:0] ROW_ROAD_LAST   = 6'd12;
    localparam logic [3:0] ROAD_LANE0      = 4'd5;

    // Bit c of a seed is column c of that lane.
    localparam logic [LANE_W-1:0] LANE_SEED [NUM_LANES] = '{
        20'h0F0F0, 20'h0003C, 20'h7C01F, 20'h00FF0, 20'h0E1C3,
        20'h10421, 20'h08208, 20'h21084, 20'h00C30, 20'h18006, 20'h40201
    };

    // Base ticks per rotation at level 0.
    localparam logic [3:0] LANE_PERIOD [NUM_LANES] = '{
        4'd3, 4'd4, 4'd2, 4'd5, 4'd3,
        4'd2, 4'd3, 4'd4, 4'd2, 4'd5, 4'd3
    };

    // 1 = rotate right, 0 = rotate left. Water always drifts left (matches the
    // controller's log drift); road rows alternate starting with right on row 7.
    localparam logic [NUM_LANES-1:0] LANE_DIR = 11'h2A0;

    // Level speeds a lane up by halving its period, never below one tick.
    function automatic logic [3:0] scale_period(input logic [3:0] period,
                                                input logic [1:0] level);
        logic [3:0] scaled;
        scaled = period >> level;
        return (scaled == 4'd0) ? 4'd1 : scaled;
    endfunction

endpackage

// File: rtl/frogger_lane_hazard_shifter.sv
// -----------------------------------------------------------------------------
// frogger_lane_shifter
// One lane: occupancy bitmap plus period counter. On every base tick the
// counter advances; when it reaches period-1 it clears and the bitmap rotates
// one column circularly (no bits created or lost).
// Ports: clk, rst_n (sync, active low), tick (base tick), period (scaled
// period, >= 1), dir (1 = right, 0 = left), bitmap (current occupancy).
// -----------------------------------------------------------------------------
module frogger_lane_shifter #(
    parameter int                      c_GAME_WIDTH = 20,
    parameter logic [c_GAME_WIDTH-1:0] SEED         = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic [3:0]              period,
    input  logic                    dir,
    output logic [c_GAME_WIDTH-1:0] bitmap
);

    logic [3:0] count;

    // Using >= rather than == lets a counter stranded above a freshly
    // shortened period wrap on the very next tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bitmap <= SEED;
            count  <= '0;
        end else if (tick) begin
            if (count >= period - 4'd1) begin
                count <= '0;
                // Left: column c takes column c+1. Right: column c takes c-1.
                bitmap <= dir ? {bitmap[c_GAME_WIDTH-2:0], bitmap[c_GAME_WIDTH-1]}
                              : {bitmap[0], bitmap[c_GAME_WIDTH-1:1]};
            end else begin
                count <= count + 4'd1;
            end
        end
    end

endmodule

// File: rtl/frogger_lane_hazard.sv
// -----------------------------------------------------------------------------
// frogger_lane_hazard
// Lane/obstacle engine for Frogger. Owns every car and log lane, answers the
// frog cell (collision, on-log, tile) and a second renderer tile query.
// Ports:
//   i_Clk, i_Rst_N          clock, synchronous active-low reset
//   i_Game_Active           lanes move and hazard flags are valid when 1
//   i_Level                 speed level 0..3
//   i_Frogger_X/Y           frog cell
//   i_Col/Row_Count_Div     renderer query cell
//   o_Collided, o_On_Log    frog hazard flags (registered)
//   o_Tile_Data             tile at frog cell (registered)
//   o_Render_Tile           tile at renderer cell (registered)
// -----------------------------------------------------------------------------
module frogger_lane_hazard
    import frogger_lane_hazard_pkg::*;
#(
    parameter int                      c_GAME_WIDTH  = 20,
    parameter int                      c_GAME_HEIGHT = 15,
    parameter int                      c_TICK_COUNT  = 2500000,
    parameter logic [c_GAME_WIDTH-1:0] c_HOME_MASK   = 20'h24924
) (
    input  logic       i_Clk,
    input  logic       i_Rst_N,
    input  logic       i_Game_Active,
    input  logic [1:0] i_Level,
    input  logic [5:0] i_Frogger_X,
    input  logic [5:0] i_Frogger_Y,
    input  logic [5:0] i_Col_Count_Div,
    input  logic [5:0] i_Row_Count_Div,
    output logic       o_Collided,
    output logic       o_On_Log,
    output logic [3:0] o_Tile_Data,
    output logic [3:0] o_Render_Tile
);

    localparam int         PRESC_W = (c_TICK_COUNT > 1) ? $clog2(c_TICK_COUNT) : 1;
    localparam logic [5:0] GW6     = 6'(c_GAME_WIDTH);
    localparam logic [5:0] GH6     = 6'(c_GAME_HEIGHT);

    typedef logic [NUM_LANES-1:0][c_GAME_WIDTH-1:0] lane_bus_t;

    logic [PRESC_W-1:0] presc;
    logic               base_tick;
    lane_bus_t          lanes;
    logic [3:0]         frog_tile;
    logic [3:0]         query_tile;

    assign base_tick = i_Game_Active && (presc == PRESC_W'(c_TICK_COUNT - 1));

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_N) begin
            presc <= '0;
        end else if (i_Game_Active) begin
            presc <= base_tick ? '0 : presc + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [3:0] lane_period;
        assign lane_period = scale_period(LANE_PERIOD[i], i_Level);

        frogger_lane_shifter #(
            .c_GAME_WIDTH (c_GAME_WIDTH),
            .SEED         (c_GAME_WIDTH'(LANE_SEED[i]))
        ) u_shifter (
            .clk    (i_Clk),
            .rst_n  (i_Rst_N),
            .tick   (base_tick),
            .period (lane_period),
            .dir    (LANE_DIR[i]),
            .bitmap (lanes[i])
        );
    end

    // Decode one cell: pick the row's bitmap (home mask or lane), extract the
    // column bit, then map it to a tile code by row class.
    function automatic logic [3:0] tile_at(input logic [5:0] x,
                                           input logic [5:0] y,
                                           input lane_bus_t  maps);
        logic [c_GAME_WIDTH-1:0] row_bits;
        logic [c_GAME_WIDTH-1:0] shifted;
        logic [3:0]              tile;
        logic                    occ;
        row_bits = '0;
        tile     = TILE_SAFE;
        if (y == ROW_HOME) begin
            row_bits = c_HOME_MASK;
        end else if (y >= ROW_WATER_FIRST && y <= ROW_WATER_LAST) begin
            row_bits = maps[4'(y - ROW_WATER_FIRST)];
        end else if (y >= ROW_ROAD_FIRST && y <= ROW_ROAD_LAST) begin
            row_bits = maps[4'(y - ROW_ROAD_FIRST) + ROAD_LANE0];
        end
        shifted = row_bits >> x;
        occ     = shifted[0];
        if (x < GW6 && y < GH6) begin
            if (y == ROW_HOME)
                tile = occ ? TILE_PAD : TILE_SAFE;
            else if (y >= ROW_WATER_FIRST && y <= ROW_WATER_LAST)
                tile = occ ? TILE_LOG : TILE_WATER;
            else if (y >= ROW_ROAD_FIRST && y <= ROW_ROAD_LAST)
                tile = occ ? TILE_CAR : TILE_ROAD;
        end
        return tile;
    endfunction

    assign frog_tile  = tile_at(i_Frogger_X, i_Frogger_Y, lanes);
    assign query_tile = tile_at(i_Col_Count_Div, i_Row_Count_Div, lanes);

    // Lookups read the bitmaps before any rotation landing on the same edge.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_N) begin
            o_Collided    <= 1'b0;
            o_On_Log      <= 1'b0;
            o_Tile_Data   <= '0;
            o_Render_Tile <= '0;
        end else begin
            o_Collided    <= i_Game_Active && (frog_tile == TILE_CAR);
            o_On_Log      <= i_Game_Active && (frog_tile == TILE_LOG);
            o_Tile_Data   <= frog_tile;
            o_Render_Tile <= query_tile;
        end
    end

endmodule

// File: tb/tb_frogger_lane_hazard.sv
// -----------------------------------------------------------------------------
// tb_frogger_lane_hazard
// Directed scenarios followed by a randomized run, all compared against a
// column-array model of the lanes built from the game rules.
// -----------------------------------------------------------------------------
module tb_frogger_lane_hazard;

    localparam int W = 20;
    localparam int H = 15;
    localparam int TICK = 4;
    localparam int NL = 11;

    logic       clk = 1'b0;
    logic       rst_n, active;
    logic [1:0] level;
    logic [5:0] fx, fy, rx, ry;
    logic       o_Collided, o_On_Log;
    logic [3:0] o_Tile_Data, o_Render_Tile;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    frogger_lane_hazard #(
        .c_GAME_WIDTH  (W),
        .c_GAME_HEIGHT (H),
        .c_TICK_COUNT  (TICK),
        .c_HOME_MASK   (20'h24924)
    ) dut (
        .i_Clk           (clk),
        .i_Rst_N         (rst_n),
        .i_Game_Active   (active),
        .i_Level         (level),
        .i_Frogger_X     (fx),
        .i_Frogger_Y     (fy),
        .i_Col_Count_Div (rx),
        .i_Row_Count_Div (ry),
        .o_Collided      (o_Collided),
        .o_On_Log        (o_On_Log),
        .o_Tile_Data     (o_Tile_Data),
        .o_Render_Tile   (o_Render_Tile)
    );

    // Lane tables: lanes 0..4 are water rows 1..5, lanes 5..10 road rows 7..12.
    localparam logic [19:0] SEEDS [NL] = '{
        20'h0F0F0, 20'h0003C, 20'h7C01F, 20'h00FF0, 20'h0E1C3,
        20'h10421, 20'h08208, 20'h21084, 20'h00C30, 20'h18006, 20'h40201
    };
    int PER   [NL] = '{3, 4, 2, 5, 3, 2, 3, 4, 2, 5, 3};
    bit RIGHT [NL] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0};

    bit occ [NL][W];
    int lane_ticks [NL];
    int presc_m;

    task automatic model_reset();
        logic [19:0] s;
        for (int i = 0; i < NL; i++) begin
            s = SEEDS[i];
            for (int c = 0; c < W; c++) occ[i][c] = s[c];
            lane_ticks[i] = 0;
        end
        presc_m = 0;
    endtask

    task automatic model_advance(input bit act, input int lvl);
        bit old [W];
        int sp;
        if (act) begin
            presc_m++;
            if (presc_m == TICK) begin
                presc_m = 0;
                for (int i = 0; i < NL; i++) begin
                    sp = PER[i] >> lvl;
                    if (sp < 1) sp = 1;
                    lane_ticks[i]++;
                    if (lane_ticks[i] >= sp) begin
                        lane_ticks[i] = 0;
                        old = occ[i];
                        for (int c = 0; c < W; c++)
                            occ[i][c] = RIGHT[i] ? old[(c + W - 1) % W] : old[(c + 1) % W];
                    end
                end
            end
        end
    endtask

    function automatic int exp_tile(int x, int y);
        if (x >= W || y >= H) return 0;
        if (y == 0) return (x % 3 == 2) ? 4 : 0;
        if (y >= 1 && y <= 5) return occ[y - 1][x] ? 3 : 2;
        if (y >= 7 && y <= 12) return occ[y - 2][x] ? 5 : 1;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: predict from the pre-edge model, advance it, compare #1 later.
    task automatic cycle();
        int et, er, ec, el;
        @(posedge clk);
        if (!rst_n) begin
            et = 0; er = 0; ec = 0; el = 0;
            model_reset();
        end else begin
            et = exp_tile(int'(fx), int'(fy));
            er = exp_tile(int'(rx), int'(ry));
            ec = (active && et == 5) ? 1 : 0;
            el = (active && et == 3) ? 1 : 0;
            model_advance(active, int'(level));
        end
        #1;
        check("tile",     o_Tile_Data,   4'(et));
        check("render",   o_Render_Tile, 4'(er));
        check("collided", {3'b0, o_Collided}, 4'(ec));
        check("on_log",   {3'b0, o_On_Log},   4'(el));
        check("exclusive", {3'b0, o_Collided & o_On_Log}, 4'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int pop;
        rst_n = 1'b0; active = 1'b0; level = 2'd0;
        fx = '0; fy = '0; rx = '0; ry = '0;
        model_reset();

        // Reset: two cycles low, all outputs zero.
        cycle();
        cycle();
        check("reset_tile",   o_Tile_Data,   4'd0);
        check("reset_render", o_Render_Tile, 4'd0);
        rst_n = 1'b1;

        // Every lane equals its seed: scan the whole board while inactive.
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                rx = 6'(x); ry = 6'(y);
                cycle();
            end

        // Car seeded at column 3 on row 8.
        active = 1'b1; fx = 6'd3; fy = 6'd8;
        cycle();
        check("car_collided", {3'b0, o_Collided}, 4'd1);
        check("car_tile",     o_Tile_Data,        4'd5);
        check("car_on_log",   {3'b0, o_On_Log},   4'd0);

        // Row 2 log under frog at col 5, gap arrives after first rotation (16
        // clocks). Row 1 (period 3) rotates every 12 clocks at level 0.
        do_reset();
        active = 1'b1; level = 2'd0; fx = 6'd5; fy = 6'd2; rx = 6'd15; ry = 6'd1;
        for (int n = 1; n <= 17; n++) begin
            cycle();
            if (n == 1)  check("log_tile_first", o_Tile_Data, 4'd3);
            if (n == 12) check("p3_pre_rot",  o_Render_Tile, 4'd3);
            if (n == 13) check("p3_post_rot", o_Render_Tile, 4'd2);
            if (n == 16) begin
                check("log_on", {3'b0, o_On_Log}, 4'd1);
                check("log_tile", o_Tile_Data, 4'd3);
            end
            if (n == 17) begin
                check("gap_on", {3'b0, o_On_Log}, 4'd0);
                check("gap_tile", o_Tile_Data, 4'd2);
            end
        end

        // Level 2: period 3 scales to 1, so row 1 rotates every 4 clocks.
        do_reset();
        active = 1'b1; level = 2'd2; fx = 6'd3; fy = 6'd8; rx = 6'd15; ry = 6'd1;
        for (int n = 1; n <= 5; n++) begin
            cycle();
            if (n == 4) check("lvl2_pre_rot",  o_Render_Tile, 4'd3);
            if (n == 5) check("lvl2_post_rot", o_Render_Tile, 4'd2);
        end

        // Inactive for 50 cycles: nothing moves, flags forced low.
        active = 1'b0; rx = 6'd10; fx = 6'd5; fy = 6'd1;
        for (int n = 0; n < 50; n++) begin
            cycle();
            check("hold_render", o_Render_Tile, 4'd2);
            check("hold_onlog",  {3'b0, o_On_Log}, 4'd0);
        end
        // Prescaler also held: the next tick lands on the third active edge.
        active = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            cycle();
            if (n == 3) check("resume_pre",  o_Render_Tile, 4'd2);
            if (n == 4) check("resume_post", o_Render_Tile, 4'd3);
        end

        // Row 3 (left, period 2): column 0 bit reaches column 19 after one
        // rotation; then 40 rotations total, population preserved.
        do_reset();
        active = 1'b1; level = 2'd0; rx = 6'd19; ry = 6'd3; fx = 6'd0; fy = 6'd14;
        for (int n = 1; n <= 320; n++) begin
            cycle();
            if (n == 8) check("wrap_pre",  o_Render_Tile, 4'd2);
            if (n == 9) check("wrap_post", o_Render_Tile, 4'd3);
        end
        active = 1'b0;
        pop = 0;
        for (int x = 0; x < W; x++) begin
            rx = 6'(x);
            cycle();
            if (o_Render_Tile == 4'd3) pop++;
        end
        check("popcount", 4'(pop), 4'd10);

        // Out of range and home row.
        active = 1'b1; fx = 6'd25; fy = 6'd3; rx = 6'd0; ry = 6'd0;
        cycle();
        check("oor_tile",   o_Tile_Data,        4'd0);
        check("oor_onlog",  {3'b0, o_On_Log},   4'd0);
        check("home_clear", o_Render_Tile,      4'd0);
        fx = 6'd4; fy = 6'd15; rx = 6'd2;
        cycle();
        check("oor_y_tile", o_Tile_Data,   4'd0);
        check("home_pad",   o_Render_Tile, 4'd4);
        rx = 6'd20; ry = 6'd0;
        cycle();
        check("render_oor", o_Render_Tile, 4'd0);

        // Randomized run with level changes, pauses and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rst_n  = ($urandom_range(0, 199) != 0);
            active = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) level = 2'($urandom_range(0, 3));
            fx = 6'($urandom_range(0, 22));
            fy = 6'($urandom_range(0, 16));
            rx = 6'($urandom_range(0, 22));
            ry = 6'($urandom_range(0, 16));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
